// File: rtl/enemy_fire_scheduler_if.sv
// Handshake bundle between the game FSM and the enemy fire scheduler.
// The master drives the alive map, enable and bullet status; the slave issues shots.
interface enemy_fire_scheduler_if #(
    parameter int LINHAS  = 4,
    parameter int COLUNAS = 10
);
    logic                        enable;
    logic [LINHAS*COLUNAS-1:0]   vivo_inimigo;
    logic                        bullet_busy;
    logic                        fire;
    logic [3:0]                  shooter_col;
    logic [1:0]                  shooter_row;
    logic                        active;

    modport master (
        output enable, vivo_inimigo, bullet_busy,
        input  fire, shooter_col, shooter_row, active
    );

    modport slave (
        input  enable, vivo_inimigo, bullet_busy,
        output fire, shooter_col, shooter_row, active
    );
endinterface

// File: rtl/enemy_fire_scheduler.sv
// Picks the bottom-most living enemy of a column, round-robin across columns,
// and requests one enemy bullet at a time with a cooldown between shots.
module enemy_fire_scheduler #(
    parameter int LINHAS   = 4,
    parameter int COLUNAS  = 10,
    parameter int COOLDOWN = 12_500_000
) (
    input  logic clk,
    input  logic reset,
    enemy_fire_scheduler_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_COOL, S_SCAN, S_FIRE, S_WAIT
    } state_t;

    localparam int N  = LINHAS * COLUNAS;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [CW-1:0] RELOAD   = CW'(COOLDOWN - 1);
    localparam logic [3:0]    LAST_COL = 4'(COLUNAS - 1);
    localparam logic [4:0]    LAST_EMP = 5'(COLUNAS - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    ptr, ptr_n;
    logic [3:0]    col, col_n;
    logic [4:0]    emp, emp_n;
    logic [3:0]    scol, scol_n;
    logic [1:0]    srow, srow_n;
    logic          active_q;
    logic          fire;
    logic          hit;
    logic [1:0]    hit_row;
    logic [IW-1:0] idx;
    logic [IW-1:0] sidx;
    logic          shooter_alive;

    function automatic logic [3:0] next_col(input logic [3:0] c);
        return (c == LAST_COL) ? 4'd0 : c + 4'd1;
    endfunction

    // Later rows overwrite earlier ones, leaving the bottom-most survivor.
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        idx     = '0;
        for (int r = 0; r < LINHAS; r++) begin
            idx = IW'(r * COLUNAS) + IW'(col);
            if (bus.vivo_inimigo[idx]) begin
                hit     = 1'b1;
                hit_row = 2'(r);
            end
        end
    end

    assign sidx          = IW'(srow) * IW'(COLUNAS) + IW'(scol);
    assign shooter_alive = bus.vivo_inimigo[sidx];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        col_n   = col;
        emp_n   = emp;
        scol_n  = scol;
        srow_n  = srow;
        fire    = 1'b0;
        if (!bus.enable) begin
            state_n = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n = S_COOL;
                    cnt_n   = RELOAD;
                end
                S_COOL: begin
                    if (cnt == '0) begin
                        state_n = S_SCAN;
                        col_n   = ptr;
                        emp_n   = '0;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                S_SCAN: begin
                    if (hit) begin
                        scol_n  = col;
                        srow_n  = hit_row;
                        state_n = S_FIRE;
                    end else if (emp == LAST_EMP) begin
                        state_n = S_COOL;
                        cnt_n   = RELOAD;
                    end else begin
                        emp_n = emp + 5'd1;
                        col_n = next_col(col);
                    end
                end
                // A dead shooter forfeits the shot; rescan from its column.
                S_FIRE: begin
                    if (!shooter_alive) begin
                        state_n = S_SCAN;
                        col_n   = scol;
                        emp_n   = '0;
                    end else if (!bus.bullet_busy) begin
                        fire    = 1'b1;
                        ptr_n   = next_col(scol);
                        state_n = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!bus.bullet_busy) begin
                        state_n = S_COOL;
                        cnt_n   = RELOAD;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            col      <= '0;
            emp      <= '0;
            scol     <= '0;
            srow     <= '0;
            active_q <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ptr      <= ptr_n;
            col      <= col_n;
            emp      <= emp_n;
            scol     <= scol_n;
            srow     <= srow_n;
            active_q <= (state_n != S_IDLE);
        end
    end

    assign bus.fire        = fire;
    assign bus.shooter_col = scol;
    assign bus.shooter_row = srow;
    assign bus.active      = active_q;
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed scenarios for the enemy fire scheduler with a shot scoreboard.
// Edges are counted from the first edge that samples enable.
module tb_enemy_fire_scheduler;
    localparam int L  = 4;
    localparam int C  = 10;
    localparam int CD = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cmp = 0;
    int   err = 0;
    int   dbl = 0;
    logic prev_fire = 1'b0;
    logic [5:0] sb[$];
    logic [5:0] exp_s;
    int   n;
    logic bad;

    enemy_fire_scheduler_if #(.LINHAS(L), .COLUNAS(C)) bus ();

    enemy_fire_scheduler #(
        .LINHAS(L), .COLUNAS(C), .COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (prev_fire && bus.fire) dbl++;
        prev_fire <= bus.fire;
    end

    task automatic wait_fire(input int budget, output int cnt_o);
        cnt_o = 0;
        do begin
            @(negedge clk);
            cnt_o++;
        end while (bus.fire !== 1'b1 && cnt_o < budget);
        if (bus.fire !== 1'b1) cnt_o = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.bullet_busy = 1'b0;
        bus.vivo_inimigo = '0;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.enable = 1'b1;
        bus.vivo_inimigo = '1;
        bus.bullet_busy = 1'b0;
        repeat (3) @(negedge clk);
        cmp++;
        if ({bus.fire, bus.shooter_col, bus.shooter_row, bus.active} !== 8'h00) begin
            err++;
            $display("FAIL reset_outputs: got %b want 00000000",
                     {bus.fire, bus.shooter_col, bus.shooter_row, bus.active});
        end
        reset = 1'b0;
        bus.enable = 1'b0;
    endtask

    task automatic test_first_shot();
        do_reset();
        bus.vivo_inimigo = '1;
        bus.enable = 1'b1;
        sb.push_back({4'd0, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL first_latency: got %0d edges want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL first_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
        @(negedge clk);
        cmp++;
        if (bus.fire !== 1'b0) begin
            err++;
            $display("FAIL fire_one_cycle: got %b want 0", bus.fire);
        end
        sb.push_back({4'd1, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL second_latency: got %0d want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL second_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_single_target();
        do_reset();
        bus.vivo_inimigo = 40'd1 << 27;
        bus.enable = 1'b1;
        sb.push_back({4'd7, 2'd2});
        wait_fire(60, n);
        cmp++;
        if (n !== 13) begin
            err++;
            $display("FAIL scan_latency: got %0d want 13", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL single_target: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
        @(negedge clk);
        bus.vivo_inimigo = '1;
        sb.push_back({4'd8, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL ptr_latency: got %0d want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL ptr_advance: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_empty_field();
        do_reset();
        bus.vivo_inimigo = '0;
        bus.enable = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.fire !== 1'b0 || bus.active !== 1'b1) bad = 1'b1;
        end
        cmp++;
        if (bad !== 1'b0) begin
            err++;
            $display("FAIL empty_quiet: got fire/active deviation %b want 0", bad);
        end
        bus.vivo_inimigo = 40'd1 << 30;
        sb.push_back({4'd0, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 5) begin
            err++;
            $display("FAIL empty_rescan: got %0d want 5", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL empty_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_busy();
        do_reset();
        bus.vivo_inimigo = '1;
        bus.bullet_busy = 1'b1;
        bus.enable = 1'b1;
        sb.push_back({4'd0, 2'd3});
        bad = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.fire !== 1'b0) bad = 1'b1;
        end
        cmp++;
        if (bad !== 1'b0) begin
            err++;
            $display("FAIL busy_hold: got fire while busy %b want 0", bad);
        end
        bus.bullet_busy = 1'b0;
        #1;
        cmp++;
        if (bus.fire !== 1'b1) begin
            err++;
            $display("FAIL busy_release: got %b want 1", bus.fire);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL busy_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
        @(negedge clk);
        bus.bullet_busy = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.fire !== 1'b0 || bus.active !== 1'b1) bad = 1'b1;
        end
        cmp++;
        if (bad !== 1'b0) begin
            err++;
            $display("FAIL wait_hold: got deviation %b want 0", bad);
        end
        bus.bullet_busy = 1'b0;
        sb.push_back({4'd1, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL wait_exit: got %0d want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL wait_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_shooter_killed();
        do_reset();
        bus.vivo_inimigo = '1;
        bus.bullet_busy = 1'b1;
        bus.enable = 1'b1;
        repeat (6) @(negedge clk);
        bus.vivo_inimigo[30] = 1'b0;
        bus.bullet_busy = 1'b0;
        #1;
        cmp++;
        if (bus.fire !== 1'b0) begin
            err++;
            $display("FAIL dead_no_fire: got %b want 0", bus.fire);
        end
        sb.push_back({4'd0, 2'd2});
        wait_fire(20, n);
        cmp++;
        if (n !== 2) begin
            err++;
            $display("FAIL dead_rescan: got %0d want 2", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL dead_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        bus.vivo_inimigo = '1;
        bus.enable = 1'b1;
        sb.push_back({4'd0, 2'd3});
        wait_fire(40, n);
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if (n !== 6 || {bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL drop_pre: got %0d c%0d want 6 c%0d",
                     n, bus.shooter_col, exp_s[5:2]);
        end
        repeat (3) @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        cmp++;
        if ({bus.active, bus.fire, bus.shooter_col} !== 6'b000000) begin
            err++;
            $display("FAIL drop_idle: got %b want 000000",
                     {bus.active, bus.fire, bus.shooter_col});
        end
        repeat (2) @(negedge clk);
        bus.enable = 1'b1;
        sb.push_back({4'd1, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL drop_restart: got %0d want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL drop_ptr: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        bus.vivo_inimigo = 40'd1 << 35;
        bus.enable = 1'b1;
        sb.push_back({4'd5, 2'd3});
        wait_fire(60, n);
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if (n !== 11 || {bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL col5_shot: got %0d c%0d r%0d want 11 c%0d r%0d",
                     n, bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
        @(negedge clk);
        bus.bullet_busy = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        cmp++;
        if ({bus.fire, bus.shooter_col, bus.shooter_row, bus.active} !== 8'h00) begin
            err++;
            $display("FAIL wait_reset: got %b want 00000000",
                     {bus.fire, bus.shooter_col, bus.shooter_row, bus.active});
        end
        reset = 1'b0;
        bus.bullet_busy = 1'b0;
        bus.vivo_inimigo = '1;
        sb.push_back({4'd0, 2'd3});
        wait_fire(40, n);
        cmp++;
        if (n !== 6) begin
            err++;
            $display("FAIL post_reset_latency: got %0d want 6", n);
        end
        exp_s = (sb.size() > 0) ? sb.pop_front() : 6'h3f;
        cmp++;
        if ({bus.shooter_col, bus.shooter_row} !== exp_s) begin
            err++;
            $display("FAIL post_reset_shot: got c%0d r%0d want c%0d r%0d",
                     bus.shooter_col, bus.shooter_row, exp_s[5:2], exp_s[1:0]);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        bus.bullet_busy = 1'b0;
        bus.vivo_inimigo = '0;
        test_reset();
        test_first_shot();
        test_single_target();
        test_empty_field();
        test_busy();
        test_shooter_killed();
        test_enable_drop();
        test_reset_mid_wait();
        cmp++;
        if (dbl !== 0) begin
            err++;
            $display("FAIL fire_back_to_back: got %0d pairs want 0", dbl);
        end
        cmp++;
        if (sb.size() !== 0) begin
            err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end
endmodule

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- LINHAS, 4, enemy rows
- COLUNAS, 10, enemy columns, range 2..16
- COOLDOWN, 12_500_000, clock cycles between a bullet retiring and the next scan; minimum 1
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  game-in-progress qualifier (state 1 of the game FSM)
- vivo_inimigo  in  LINHAS*COLUNAS  alive flags; bit index = row*COLUNAS+col; row 0 = top
- bullet_busy  in  1  enemy bullet (municao2) in flight
- fire  out  1  one-cycle shot request
- shooter_col  out  4  column of the selected shooter
- shooter_row  out  2  row of the selected shooter
- active  out  1  high when FSM is not IDLE
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.

Function
REQ-004 The FSM SHALL have states IDLE, COOLDOWN, SCAN, FIRE and WAIT.
REQ-005 IDLE transitions:
- enable=1 -> COOLDOWN, counter loaded with COOLDOWN-1
- otherwise stay in IDLE
REQ-006 COOLDOWN:
- counter decrements once per cycle
- counter==0 -> SCAN, scan column loaded from round-robin pointer ptr
- COOLDOWN state lasts exactly COOLDOWN cycles
REQ-007 SCAN examines one column per cycle; the target in a column is the highest-index (bottom-most) row whose alive bit is 1.
REQ-008 Target found in SCAN:
- latch shooter_col and shooter_row in that cycle
- go to FIRE
REQ-009 No target in SCAN:
- advance scan column by 1, wrapping COLUNAS-1 -> 0
- after COLUNAS consecutive empty columns -> COOLDOWN (reload), fire not asserted
REQ-010 FIRE:
- fire = (state==FIRE) && !bullet_busy
- while bullet_busy=1, stay in FIRE with fire low
- on the cycle fire is high: ptr <= (shooter_col+1) wrapped mod COLUNAS, then -> WAIT
REQ-011 WAIT:
- stay while bullet_busy=1
- bullet_busy=0 -> COOLDOWN (reload)
- WAIT lasts at least 1 cycle
REQ-012 fire SHALL never be high for two consecutive cycles.
REQ-013 fire SHALL only be high when the latched shooter's alive bit is 1 in that same cycle.
REQ-014 If the latched shooter dies while in FIRE: fire stays low and the FSM goes back to SCAN starting at the same column.
REQ-015 enable=0 in any state:
- FIRE: fire is low that cycle
- -> IDLE on the next edge
- ptr and shooter outputs hold their values
REQ-016 shooter_col/shooter_row SHALL change only on a SCAN latch and otherwise hold.
REQ-017 active = (state != IDLE), registered together with the state.

Reset
REQ-018 On reset, regardless of state, on the next edge:
- state IDLE, counter 0, ptr 0, scan column 0
- fire 0, shooter_col 0, shooter_row 0, active 0
REQ-019 reset SHALL take priority over enable and all other inputs.

Verification
REQ-020 Directed scenarios (all with COOLDOWN=4):
- All alive, bullet_busy=0, enable asserted -> fire high exactly 6 edges after enable is first sampled, with col 0, row 3; next shot at col 1 after WAIT plus 4 COOLDOWN cycles.
- Only bit 27 (row 2, col 7) alive, ptr=0 -> SCAN visits cols 0..7 (8 cycles), then fire with col 7, row 2; ptr becomes 8.
- vivo_inimigo all 0 -> 10 SCAN cycles, return to COOLDOWN, fire never asserted, active stays 1.
- bullet_busy=1 when entering FIRE -> fire low until busy drops; fire then high one cycle; hold busy 20 cycles in WAIT -> COOLDOWN begins the cycle after busy falls.
- enable dropped during COOLDOWN, then reasserted -> IDLE next edge, active=0, ptr preserved; restart performs a full 4-cycle COOLDOWN.
- reset asserted mid-WAIT with shooter col 5 -> next edge all outputs 0, ptr 0; first shot after enable comes from col 0.
